// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - core request/response and memory bus signals for mem_bus_master
interface mem_bus_master_if #(
  parameter int WIDTH = 16
);
  // core side
  logic             req;
  logic             wr;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] rdata;
  // memory side
  logic             EN;
  logic             RW;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             MFC;

  modport master (
    input  req, wr, addr_in, wdata, dataout, MFC,
    output busy, done, err, rdata, EN, RW, addr, datain
  );

  modport slave (
    output req, wr, addr_in, wdata, dataout, MFC,
    input  busy, done, err, rdata, EN, RW, addr, datain
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - asynchronous-handshake memory bus master (EN/MFC strobe protocol)
module mem_bus_master #(
  parameter int TIMEOUT = 64,
  parameter int WIDTH   = 16
) (
  input logic              clk,
  input logic              resetn,
  mem_bus_master_if.master bus
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    FINISH
  } state_t;

  state_t           state, state_n;
  logic             mfc_meta, mfc_s;
  logic [CW-1:0]    cnt, cnt_n;
  logic             abort, abort_n;
  logic             armed, armed_n;
  logic             capture;

  logic             en_q, rw_q, busy_q, done_q, err_q;
  logic [WIDTH-1:0] addr_q, datain_q, rdata_q;

  assign bus.EN     = en_q;
  assign bus.RW     = rw_q;
  assign bus.addr   = addr_q;
  assign bus.datain = datain_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

  // Two-flop synchronizer; MFC comes from another timing domain
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mfc_meta <= 1'b0;
      mfc_s    <= 1'b0;
    end else begin
      mfc_meta <= bus.MFC;
      mfc_s    <= mfc_meta;
    end
  end

  // State, timeout counter, abort flag and stale-MFC guard registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      abort <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      abort <= abort_n;
      armed <= armed_n;
    end
  end

  // Next-state logic; armed only goes high after mfc_s has been seen low in
  // STROBE, so an MFC left high from a previous access is never taken as done
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    abort_n = abort;
    armed_n = armed;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_n = SETUP;
          abort_n = 1'b0;
        end
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = '0;
        armed_n = 1'b0;
      end
      STROBE: begin
        if (!mfc_s) armed_n = 1'b1;
        if (mfc_s && armed) begin
          capture = 1'b1;
          state_n = RELEASE;
          cnt_n   = '0;
        end else if (cnt == TMAX) begin
          abort_n = 1'b1;
          state_n = RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!mfc_s) begin
          state_n = FINISH;
        end else if (cnt == TMAX) begin
          abort_n = 1'b1;
          state_n = FINISH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q     <= 1'b0;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      datain_q <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.req) begin
        addr_q   <= bus.addr_in;
        datain_q <= bus.wdata;
        rw_q     <= ~bus.wr;
      end
      if (capture && rw_q) rdata_q <= bus.dataout;
      en_q   <= (state_n == STROBE);
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == FINISH) && !abort_n;
      err_q  <= (state_n == FINISH) && abort_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master with memory model and scoreboard
module tb_mem_bus_master;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master_if #(.WIDTH(W)) bus ();

  mem_bus_master #(.TIMEOUT(TMO), .WIDTH(W)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct packed {
    logic         err;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic         wr;
    logic [W-1:0] a;
    logic [W-1:0] d;
    int           dly;
    logic [W-1:0] exp_rd;
  } vec_t;

  exp_t     sb[$];
  int       tests = 0;
  int       fails = 0;

  // memory model controls
  logic [W-1:0] mem [0:255];
  int           mfc_delay = 3;
  logic         mfc_never = 1'b0;
  logic         model_on  = 1'b1;
  logic         man_mfc   = 1'b0;
  logic [W-1:0] man_data  = '0;
  int           en_cycles;

  function automatic void chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endfunction

  function automatic void chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  function automatic void push_exp(input logic e, input logic [W-1:0] rd);
    exp_t x;
    x.err   = e;
    x.rdata = rd;
    sb.push_back(x);
  endfunction

  // memory: latches write/read on EN rise, raises MFC mfc_delay cycles later, drops it once EN falls
  initial begin
    int   mfc_cnt;
    logic en_prev;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 16'hB241;
    bus.MFC = 1'b0;
    bus.dataout = '0;
    mfc_cnt = 0;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_on) begin
        bus.MFC = man_mfc;
        bus.dataout = man_data;
      end else if (bus.EN && !en_prev) begin
        if (!bus.RW) mem[bus.addr[7:0]] = bus.datain;
        bus.dataout = mem[bus.addr[7:0]];
        mfc_cnt = mfc_delay;
        if (mfc_cnt == 0 && !mfc_never) bus.MFC = 1'b1;
      end else if (bus.EN) begin
        if (mfc_cnt > 0) mfc_cnt--;
        if (mfc_cnt == 0 && !mfc_never) bus.MFC = 1'b1;
      end else begin
        bus.MFC = 1'b0;
      end
      en_prev = bus.EN;
    end
  end

  // scoreboard consumer: every done/err pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done || bus.err) begin
        chk_bit("done_err_exclusive", bus.done & bus.err, 1'b0);
        if (sb.size() == 0) begin
          fail_now("unexpected_done_or_err");
        end else begin
          e = sb.pop_front();
          chk_bit("sb_err", bus.err, e.err);
          chk_word("sb_rdata", bus.rdata, e.rdata);
        end
      end
    end
  end

  task automatic run_txn(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                         input int dly, input logic [W-1:0] exp_rd, input logic exp_err);
    logic exp_rw;
    int   n;
    exp_rw    = ~w;
    mfc_delay = dly;
    mfc_never = exp_err;
    push_exp(exp_err, exp_rd);
    bus.req = 1'b1;
    bus.wr = w;
    bus.addr_in = a;
    bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0;
    bus.wr = 1'b0;
    bus.addr_in = '0;
    bus.wdata = '0;
    chk_bit("setup_en_low", bus.EN, 1'b0);
    chk_bit("setup_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk_bit("strobe_en_high", bus.EN, 1'b1);
    chk_bit("strobe_rw", bus.RW, exp_rw);
    chk_word("strobe_addr", bus.addr, a);
    if (w) chk_word("strobe_datain", bus.datain, d);
    en_cycles = 1;
    n = 0;
    while (!(bus.done || bus.err) && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.EN) en_cycles++;
    end
    if (n >= 300) begin
      fail_now("txn_completion_wait");
    end else begin
      chk_bit("finish_rw_stable", bus.RW, exp_rw);
      chk_word("finish_addr_stable", bus.addr, a);
      chk_bit("finish_en_low", bus.EN, 1'b0);
    end
    @(negedge clk);
    chk_bit("idle_busy_low", bus.busy, 1'b0);
    mfc_never = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   ndone;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 3, 16'hB241};
    vecs[1] = '{1'b1, 16'h0010, 16'h1234, 3, 16'hB241};
    vecs[2] = '{1'b0, 16'h0010, 16'h0000, 1, 16'h1234};
    vecs[3] = '{1'b1, 16'h0020, 16'hA5A5, 5, 16'h1234};
    vecs[4] = '{1'b0, 16'h0020, 16'h0000, 0, 16'hA5A5};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 2, 16'hB241};
    vecs[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 2, 16'hB241};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0000, 4, 16'hFFFF};

    bus.req = 1'b0;
    bus.wr = 1'b0;
    bus.addr_in = '0;
    bus.wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_bit("rst_done", bus.done, 1'b0);
    chk_bit("rst_err", bus.err, 1'b0);
    chk_bit("rst_en", bus.EN, 1'b0);
    chk_bit("rst_rw", bus.RW, 1'b1);
    chk_word("rst_addr", bus.addr, 16'h0000);
    chk_word("rst_datain", bus.datain, 16'h0000);
    chk_word("rst_rdata", bus.rdata, 16'h0000);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].dly, vecs[i].exp_rd, 1'b0);

    // MFC never comes: abort after the timeout, rdata untouched
    run_txn(1'b0, 16'h0010, 16'h0000, 0, 16'hFFFF, 1'b1);
    chk_bit("timeout_en_cycles_in_range", (en_cycles >= TMO) && (en_cycles <= TMO + 2), 1'b1);

    // req held high for three reads: IDLE gap after each done, then nothing more
    mfc_delay = 2;
    repeat (3) push_exp(1'b0, 16'hA5A5);
    bus.req = 1'b1;
    bus.wr = 1'b0;
    bus.addr_in = 16'h0020;
    ndone = 0;
    n = 0;
    while (ndone < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        ndone++;
        if (ndone == 3) bus.req = 1'b0;
        @(negedge clk);
        chk_bit("b2b_idle_gap", bus.busy, 1'b0);
        if (ndone < 3) begin
          @(negedge clk);
          chk_bit("b2b_restart", bus.busy, 1'b1);
        end
      end
    end
    if (ndone != 3) fail_now("b2b_three_done");
    repeat (10) @(negedge clk);
    chk_bit("b2b_no_fourth", bus.busy, 1'b0);
    chk_bit("b2b_sb_drained", sb.size() == 0, 1'b1);

    // reset while in STROBE: EN drops on that edge, no pulse, then normal operation
    mfc_delay = 20;
    bus.req = 1'b1;
    bus.addr_in = 16'h0000;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk_bit("mid_strobe_en", bus.EN, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    chk_bit("mid_rst_en", bus.EN, 1'b0);
    chk_bit("mid_rst_busy", bus.busy, 1'b0);
    chk_bit("mid_rst_done", bus.done, 1'b0);
    chk_bit("mid_rst_err", bus.err, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(1'b0, 16'h0000, 16'h0000, 3, 16'hB241, 1'b0);

    // stale MFC: held high on STROBE entry, must fall and rise again before capture
    model_on = 1'b0;
    man_mfc = 1'b1;
    man_data = 16'h5A5A;
    repeat (4) @(negedge clk);
    push_exp(1'b0, 16'hC3C3);
    bus.req = 1'b1;
    bus.addr_in = 16'h0030;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk_bit("stale_strobe_en", bus.EN, 1'b1);
    repeat (8) @(negedge clk);
    chk_bit("stale_hold_en", bus.EN, 1'b1);
    chk_word("stale_no_capture", bus.rdata, 16'hB241);
    man_mfc = 1'b0;
    repeat (4) @(negedge clk);
    chk_bit("stale_low_en", bus.EN, 1'b1);
    man_data = 16'hC3C3;
    man_mfc = 1'b1;
    n = 0;
    while (bus.EN && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("stale_capture_wait");
    man_mfc = 1'b0;
    n = 0;
    while (!(bus.done || bus.err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("stale_done_wait");
    model_on = 1'b1;
    repeat (3) @(negedge clk);
    chk_word("stale_rdata_final", bus.rdata, 16'hC3C3);
    chk_bit("final_sb_drained", sb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
